// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the eight requesters and rr_arbiter8.
// master = requester side, slave = arbiter side.
interface rr_arbiter8_if;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    modport master (
        output req,
        input  grant,
        input  grant_idx,
        input  grant_valid,
        input  timeout
    );

    modport slave (
        input  req,
        output grant,
        output grant_idx,
        output grant_valid,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with registered one-hot and binary grant outputs.
// Define ARB_TIMEOUT_EN to bound each ownership to MAX_HOLD cycles.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    rr_arbiter8_if.slave bus
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_check
        $error("rr_arbiter8: MAX_HOLD must be in 2..255");
    end

    typedef enum logic [0:0] {StIdle, StOwn} state_e;

    state_e     state_q, state_d;
    logic [2:0] last_q, last_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] idx_q, idx_d;
    logic       valid_q, valid_d;
    logic [2:0] rr_winner;

    // First set bit searching upward from last+1; last itself is lowest priority.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] last);
        logic [2:0] pick;
        logic [2:0] cand;
        pick = 3'd0;
        for (int k = 8; k >= 1; k--) begin
            cand = last + 3'(k);
            if (r[cand]) begin
                pick = cand;
            end
        end
        return pick;
    endfunction

    assign rr_winner = rr_pick(bus.req, last_q);

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HoldLimit = 8'(MAX_HOLD - 1);

    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;
    logic [7:0] others;

    assign others = bus.req & ~(8'b1 << last_q);
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (|bus.req) begin
                    state_d = StOwn;
                    last_d  = rr_winner;
`ifdef ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            StOwn: begin
                if (bus.req[last_q]) begin
`ifdef ARB_TIMEOUT_EN
                    if (hold_q == HoldLimit) begin
                        // Forced handoff only when someone else is waiting.
                        hold_d = '0;
                        if (|others) begin
                            last_d    = rr_pick(others, last_q);
                            timeout_d = 1'b1;
                        end
                    end else if (hold_q != 8'hFF) begin
                        hold_d = hold_q + 8'd1;
                    end
`endif
                end else if (|bus.req) begin
                    last_d = rr_winner;
`ifdef ARB_TIMEOUT_EN
                    hold_d = '0;
`endif
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        valid_d = (state_d == StOwn);
        idx_d   = valid_d ? last_d : 3'd0;
        grant_d = valid_d ? (8'b1 << last_d) : 8'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            last_q  <= 3'd7;
            grant_q <= 8'd0;
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = valid_q;

endmodule
